// File: rtl/picosoc_mem_arbiter_pkg.sv
// ============================================================================
// picosoc_mem_arbiter_pkg : shared state encodings and master indices
// Rev 1.0
// ============================================================================
`default_nettype none

package picosoc_mem_arbiter_pkg;

    typedef enum logic {
        ARB_IDLE = 1'b0,
        ARB_BUSY = 1'b1
    } arb_state_e;

    localparam logic ARB_M_CPU = 1'b0;
    localparam logic ARB_M_EXT = 1'b1;

    function automatic logic [31:0] sel32(input logic [63:0] v, input logic idx);
        return idx ? v[63:32] : v[31:0];
    endfunction

    function automatic logic [3:0] sel4(input logic [7:0] v, input logic idx);
        return idx ? v[7:4] : v[3:0];
    endfunction

endpackage

`default_nettype wire

// File: rtl/picosoc_arb_rr.sv
// ============================================================================
// picosoc_arb_rr : combinational 2-way round-robin pick (req, last -> gnt)
// Rev 1.0
// ============================================================================
`default_nettype none

module picosoc_arb_rr
    import picosoc_mem_arbiter_pkg::*;
(
    input  logic [1:0] req,
    input  logic       last,
    output logic [1:0] gnt
);

    // On contention the master that was not served last wins.
    always_comb begin
        gnt = 2'b00;
        if (req[ARB_M_CPU] && req[ARB_M_EXT]) begin
            if (last == ARB_M_EXT) begin
                gnt[ARB_M_CPU] = 1'b1;
            end else begin
                gnt[ARB_M_EXT] = 1'b1;
            end
        end else begin
            gnt = req;
        end
    end

endmodule

`default_nettype wire

// File: rtl/picosoc_mem_arbiter.sv
// ============================================================================
// picosoc_mem_arbiter : two-master round-robin arbiter for the PicoRV32 bus.
// Optional transfer timeout enabled by macro PICOSOC_ARB_TIMEOUT_EN.
// Rev 1.0
// ============================================================================
`default_nettype none

module picosoc_mem_arbiter
    import picosoc_mem_arbiter_pkg::*;
#(
    parameter int          TIMEOUT       = 255,
    parameter logic [31:0] TIMEOUT_RDATA = 32'hFFFF_FFFF
) (
    input  logic        clk,
    input  logic        resetn,
    input  logic [1:0]  m_valid,
    output logic [1:0]  m_ready,
    input  logic [63:0] m_addr,
    input  logic [63:0] m_wdata,
    input  logic [7:0]  m_wstrb,
    output logic [31:0] m_rdata,
    output logic        s_valid,
    input  logic        s_ready,
    output logic [31:0] s_addr,
    output logic [31:0] s_wdata,
    output logic [3:0]  s_wstrb,
    input  logic [31:0] s_rdata,
    output logic [1:0]  grant,
    output logic        err,
    output logic        err_master
);

    arb_state_e state;
    arb_state_e state_nxt;
    logic [1:0] grant_nxt;
    logic       last;
    logic       last_nxt;
    logic       gidx;
    logic [1:0] pick;
    logic       tmo;

    assign gidx = grant[ARB_M_EXT];

    picosoc_arb_rr u_rr (
        .req  (m_valid),
        .last (last),
        .gnt  (pick)
    );

`ifdef PICOSOC_ARB_TIMEOUT_EN
    localparam int              CW      = $clog2(TIMEOUT + 1);
    localparam logic [CW-1:0]   TO_LAST = CW'(TIMEOUT - 1);

    logic [CW-1:0] cnt;

    // Count holds TIMEOUT-1 during the TIMEOUT-th stalled BUSY cycle.
    assign tmo = (state == ARB_BUSY) && m_valid[gidx] && !s_ready && (cnt == TO_LAST);

    always_ff @(posedge clk) begin
        if (!resetn) begin
            cnt <= '0;
        end else if (state == ARB_IDLE) begin
            cnt <= '0;
        end else if (!s_ready) begin
            cnt <= cnt + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            err        <= 1'b0;
            err_master <= 1'b0;
        end else if (tmo) begin
            err        <= 1'b1;
            err_master <= gidx;
        end
    end
`else
    logic unused_cfg;

    assign tmo        = 1'b0;
    assign err        = 1'b0;
    assign err_master = 1'b0;
    assign unused_cfg = ^{TIMEOUT_RDATA, TIMEOUT[0]};
`endif

    always_comb begin
        s_valid   = 1'b0;
        s_addr    = '0;
        s_wdata   = '0;
        s_wstrb   = '0;
        m_ready   = 2'b00;
        m_rdata   = s_rdata;
        state_nxt = state;
        grant_nxt = grant;
        last_nxt  = last;
        if (state == ARB_IDLE) begin
            if (|m_valid) begin
                state_nxt = ARB_BUSY;
                grant_nxt = pick;
            end
        end else begin
            s_valid = m_valid[gidx] & ~tmo;
            s_addr  = sel32(m_addr, gidx);
            s_wdata = sel32(m_wdata, gidx);
            s_wstrb = sel4(m_wstrb, gidx);
            if (!m_valid[gidx]) begin
                // Master withdrew its request: abandon without completion.
                state_nxt = ARB_IDLE;
                grant_nxt = 2'b00;
            end else if (s_ready || tmo) begin
                m_ready[gidx] = 1'b1;
                if (tmo) begin
                    m_rdata = TIMEOUT_RDATA;
                end
                state_nxt = ARB_IDLE;
                grant_nxt = 2'b00;
                last_nxt  = gidx;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            state <= ARB_IDLE;
            grant <= 2'b00;
            last  <= ARB_M_EXT;
        end else begin
            state <= state_nxt;
            grant <= grant_nxt;
            last  <= last_nxt;
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_picosoc_mem_arbiter.sv
// ============================================================================
// tb_picosoc_mem_arbiter : directed scoreboard bench for picosoc_mem_arbiter
// Rev 1.0
// ============================================================================
`default_nettype none

module tb_picosoc_mem_arbiter;

    logic        clk = 1'b0;
    logic        resetn;
    logic [1:0]  m_valid;
    logic [1:0]  m_ready;
    logic [63:0] m_addr;
    logic [63:0] m_wdata;
    logic [7:0]  m_wstrb;
    logic [31:0] m_rdata;
    logic        s_valid;
    logic        s_ready;
    logic [31:0] s_addr;
    logic [31:0] s_wdata;
    logic [3:0]  s_wstrb;
    logic [31:0] s_rdata;
    logic [1:0]  grant;
    logic        err;
    logic        err_master;

    typedef struct packed {
        logic [1:0]  rdy;
        logic [31:0] rdata;
    } exp_t;

    exp_t sbq[$];
    int   vectors = 0;
    int   errs    = 0;

    picosoc_mem_arbiter #(.TIMEOUT(4), .TIMEOUT_RDATA(32'hFFFF_FFFF)) dut (
        .clk        (clk),
        .resetn     (resetn),
        .m_valid    (m_valid),
        .m_ready    (m_ready),
        .m_addr     (m_addr),
        .m_wdata    (m_wdata),
        .m_wstrb    (m_wstrb),
        .m_rdata    (m_rdata),
        .s_valid    (s_valid),
        .s_ready    (s_ready),
        .s_addr     (s_addr),
        .s_wdata    (s_wdata),
        .s_wstrb    (s_wstrb),
        .s_rdata    (s_rdata),
        .grant      (grant),
        .err        (err),
        .err_master (err_master)
    );

    always #5 clk = ~clk;

    initial begin
        #1000000;
        $display("FAIL watchdog: observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vectors++;
        assert (obs === exp) else begin
            errs++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic do_reset();
        resetn  = 1'b0;
        m_valid = 2'b00;
        s_ready = 1'b0;
        s_rdata = '0;
        tick();
        tick();
        resetn = 1'b1;
    endtask

    // Completes the granted transfer after `lat` stalled cycles; pops the expectation.
    task automatic complete(input int lat, input logic [31:0] rd, input logic [1:0] drop);
        exp_t e;
        for (int i = 0; i < lat; i++) begin
            chk("stall_m_ready", m_ready, 0);
            tick();
        end
        s_ready = 1'b1;
        s_rdata = rd;
        #1;
        e = (sbq.size() != 0) ? sbq.pop_front() : {2'b11, 32'hDEAD_BEEF};
        chk("done_m_ready", m_ready, e.rdy);
        chk("done_m_rdata", m_rdata, e.rdata);
        tick();
        s_ready = 1'b0;
        m_valid = m_valid & ~drop;
        #1;
        chk("gap_s_valid", s_valid, 0);
        chk("gap_grant", grant, 0);
    endtask

    initial begin
        logic [1:0] g;
        bit         seen;
        m_addr  = '0;
        m_wdata = '0;
        m_wstrb = '0;
        do_reset();
        chk("rst_grant", grant, 0);
        chk("rst_s_valid", s_valid, 0);
        chk("rst_m_ready", m_ready, 0);
        chk("rst_err", err, 0);
        chk("rst_err_master", err_master, 0);

        // Single CPU read
        m_addr[31:0] = 32'h0000_0010;
        m_valid      = 2'b01;
        #1;
        chk("t1_idle_grant", grant, 0);
        tick();
        chk("t1_grant", grant, 2'b01);
        chk("t1_s_valid", s_valid, 1);
        chk("t1_s_addr", s_addr, 32'h10);
        chk("t1_s_wstrb", s_wstrb, 0);
        sbq.push_back({2'b01, 32'h1234_5678});
        complete(2, 32'h1234_5678, 2'b01);

        // Both request from reset: alternation over 8 transfers
        do_reset();
        m_addr  = {32'h0000_0200, 32'h0000_0100};
        m_valid = 2'b11;
        for (int k = 0; k < 8; k++) begin
            tick();
            g = (k % 2 == 0) ? 2'b01 : 2'b10;
            chk("t2_grant", grant, g);
            chk("t2_s_addr", s_addr, (k % 2 == 0) ? 32'h100 : 32'h200);
            sbq.push_back({g, 32'hA000_0000 + k});
            complete(1, 32'hA000_0000 + k, (k == 7) ? 2'b11 : 2'b00);
        end

        // M1 write, M0 arrives mid-transfer
        m_addr  = {32'h0000_0300, 32'h0000_0400};
        m_wdata = {32'hCAFE_F00D, 32'h1111_1111};
        m_wstrb = {4'b0011, 4'b0000};
        m_valid = 2'b10;
        tick();
        chk("t3_grant", grant, 2'b10);
        chk("t3_s_wstrb", s_wstrb, 4'b0011);
        chk("t3_s_wdata", s_wdata, 32'hCAFE_F00D);
        chk("t3_s_addr", s_addr, 32'h300);
        m_valid = 2'b11;
        tick();
        chk("t3_hold_grant", grant, 2'b10);
        sbq.push_back({2'b10, 32'h0});
        complete(0, 32'h0, 2'b10);
        tick();
        chk("t3_m0_grant", grant, 2'b01);
        chk("t3_m0_addr", s_addr, 32'h400);
        sbq.push_back({2'b01, 32'h55AA_55AA});
        complete(0, 32'h55AA_55AA, 2'b01);

        // Reset while BUSY
        m_valid = 2'b01;
        tick();
        chk("t4_busy_grant", grant, 2'b01);
        resetn = 1'b0;
        tick();
        chk("t4_rst_grant", grant, 0);
        chk("t4_rst_s_valid", s_valid, 0);
        chk("t4_rst_m_ready", m_ready, 0);
        resetn  = 1'b1;
        m_valid = 2'b11;
        tick();
        chk("t4_after_grant", grant, 2'b01);
        sbq.push_back({2'b01, 32'h77});
        complete(0, 32'h77, 2'b11);

        // Granted master withdraws before s_ready
        m_valid = 2'b11;
        tick();
        chk("t6_grant", grant, 2'b10);
        m_valid = 2'b01;
        #1;
        chk("t6_m_ready", m_ready, 0);
        chk("t6_s_valid", s_valid, 0);
        tick();
        chk("t6_idle_grant", grant, 0);
        tick();
        chk("t6_other_grant", grant, 2'b01);
        sbq.push_back({2'b01, 32'h66});
        complete(0, 32'h66, 2'b01);

        // Slave never ready
        m_addr[31:0] = 32'h0000_0500;
        m_valid      = 2'b01;
        tick();
`ifdef PICOSOC_ARB_TIMEOUT_EN
        for (int i = 1; i < 4; i++) begin
            chk("t5_stall_m_ready", m_ready, 0);
            tick();
        end
        chk("t5_to_m_ready", m_ready, 2'b01);
        chk("t5_to_m_rdata", m_rdata, 32'hFFFF_FFFF);
        chk("t5_to_s_valid", s_valid, 0);
        tick();
        m_valid = 2'b00;
        chk("t5_err", err, 1);
        chk("t5_err_master", err_master, 0);
        chk("t5_grant", grant, 0);
`else
        seen = 1'b0;
        for (int i = 0; i < 1000; i++) begin
            if (m_ready != 2'b00) seen = 1'b1;
            tick();
        end
        chk("t5_no_ready", seen, 0);
        chk("t5_still_grant", grant, 2'b01);
        chk("t5_err", err, 0);
        sbq.push_back({2'b01, 32'h0000_0ABC});
        complete(0, 32'h0000_0ABC, 2'b01);
`endif

        chk("sb_drain", sbq.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errs);
        $finish;
    end

endmodule

`default_nettype wire
